// File: rtl/cam_rst_ctrl.sv
// rtl/cam_rst_ctrl.sv - PLL reset sequencer and lock supervisor driving sys_rst_n
module cam_rst_ctrl #(
    parameter int PLL_RST_CYCLES = 4,
    parameter int LOCK_STABLE    = 16,
    parameter int LOCK_TIMEOUT   = 1024
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pll_lock,
    output logic       pll_reset,
    output logic       sys_rst_n,
    output logic       locked,
    output logic [7:0] retry_cnt,
    output logic [7:0] loss_cnt
);

    localparam int MAX_A = (PLL_RST_CYCLES > LOCK_STABLE) ? PLL_RST_CYCLES : LOCK_STABLE;
    localparam int MAX_P = (MAX_A > LOCK_TIMEOUT) ? MAX_A : LOCK_TIMEOUT;
    localparam int CW    = (MAX_P > 1) ? $clog2(MAX_P) : 1;

    localparam logic [CW-1:0] RST_LAST = CW'(PLL_RST_CYCLES - 1);
    localparam logic [CW-1:0] STB_LAST = CW'(LOCK_STABLE - 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(LOCK_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_PLL_RST,
        ST_WAIT_LOCK,
        ST_STABLE,
        ST_RUN
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          lock_meta_q, lock_meta_d;
    logic          lock_s_q, lock_s_d;
    logic          pll_reset_q, pll_reset_d;
    logic          sys_rst_n_q, sys_rst_n_d;
    logic          locked_q, locked_d;
    logic [7:0]    retry_q, retry_d;
    logic [7:0]    loss_q, loss_d;

    always_comb begin
        lock_meta_d = pll_lock;
        lock_s_d    = lock_meta_q;
        state_d     = state_q;
        cnt_d       = cnt_q + CW'(1);
        retry_d     = retry_q;
        loss_d      = loss_q;

        case (state_q)
            ST_PLL_RST: begin
                if (cnt_q == RST_LAST) state_d = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                if (lock_s_q) begin
                    state_d = ST_STABLE;
                end else if (cnt_q == TMO_LAST) begin
                    state_d = ST_PLL_RST;
                    if (retry_q != 8'hFF) retry_d = retry_q + 8'd1;
                end
            end
            ST_STABLE: begin
                if (!lock_s_q) state_d = ST_WAIT_LOCK;
                else if (cnt_q == STB_LAST) state_d = ST_RUN;
            end
            ST_RUN: begin
                cnt_d = '0;
                if (!lock_s_q) begin
                    state_d = ST_PLL_RST;
                    if (loss_q != 8'hFF) loss_d = loss_q + 8'd1;
                end
            end
            default: state_d = ST_PLL_RST;
        endcase

        // Every phase measures its own duration from zero.
        if (state_d != state_q) cnt_d = '0;

        // Outputs follow the next state so they change on the transition edge itself.
        pll_reset_d = (state_d == ST_PLL_RST);
        sys_rst_n_d = (state_d == ST_RUN);
        locked_d    = (state_d == ST_RUN);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_PLL_RST;
            cnt_q       <= '0;
            lock_meta_q <= 1'b0;
            lock_s_q    <= 1'b0;
            pll_reset_q <= 1'b1;
            sys_rst_n_q <= 1'b0;
            locked_q    <= 1'b0;
            retry_q     <= 8'd0;
            loss_q      <= 8'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            lock_meta_q <= lock_meta_d;
            lock_s_q    <= lock_s_d;
            pll_reset_q <= pll_reset_d;
            sys_rst_n_q <= sys_rst_n_d;
            locked_q    <= locked_d;
            retry_q     <= retry_d;
            loss_q      <= loss_d;
        end
    end

    assign pll_reset = pll_reset_q;
    assign sys_rst_n = sys_rst_n_q;
    assign locked    = locked_q;
    assign retry_cnt = retry_q;
    assign loss_cnt  = loss_q;

endmodule

// File: tb/tb_cam_rst_ctrl.sv
// tb/tb_cam_rst_ctrl.sv - randomized self-checking bench for cam_rst_ctrl
module tb_cam_rst_ctrl;

    localparam int R = 4;
    localparam int S = 4;
    localparam int T = 32;

    localparam int PH_RST    = 0;
    localparam int PH_WAIT   = 1;
    localparam int PH_STABLE = 2;
    localparam int PH_RUN    = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       pll_lock;
    logic       pll_reset;
    logic       sys_rst_n;
    logic       locked;
    logic [7:0] retry_cnt;
    logic [7:0] loss_cnt;

    int tests_run    = 0;
    int tests_failed = 0;

    int m_phase, m_elapsed, m_retry, m_loss;
    int m_hist1, m_hist2;

    cam_rst_ctrl #(
        .PLL_RST_CYCLES(R),
        .LOCK_STABLE   (S),
        .LOCK_TIMEOUT  (T)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .pll_lock (pll_lock),
        .pll_reset(pll_reset),
        .sys_rst_n(sys_rst_n),
        .locked   (locked),
        .retry_cnt(retry_cnt),
        .loss_cnt (loss_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase   = PH_RST;
        m_elapsed = 0;
        m_retry   = 0;
        m_loss    = 0;
        m_hist1   = 0;
        m_hist2   = 0;
    endtask

    // Lock as the supervisor sees it is the input two edges ago.
    task automatic model_edge();
        int seen;
        seen = m_hist2;
        case (m_phase)
            PH_RST: begin
                m_elapsed++;
                if (m_elapsed == R) begin m_phase = PH_WAIT; m_elapsed = 0; end
            end
            PH_WAIT: begin
                if (seen != 0) begin
                    m_phase = PH_STABLE; m_elapsed = 0;
                end else begin
                    m_elapsed++;
                    if (m_elapsed == T) begin
                        m_phase = PH_RST; m_elapsed = 0;
                        m_retry = (m_retry < 255) ? m_retry + 1 : 255;
                    end
                end
            end
            PH_STABLE: begin
                if (seen == 0) begin
                    m_phase = PH_WAIT; m_elapsed = 0;
                end else begin
                    m_elapsed++;
                    if (m_elapsed == S) begin m_phase = PH_RUN; m_elapsed = 0; end
                end
            end
            default: begin
                if (seen == 0) begin
                    m_phase = PH_RST; m_elapsed = 0;
                    m_loss = (m_loss < 255) ? m_loss + 1 : 255;
                end
            end
        endcase
        m_hist2 = m_hist1;
        m_hist1 = int'(pll_lock);
    endtask

    task automatic check_outputs();
        check("pll_reset", int'(pll_reset), (m_phase == PH_RST) ? 1 : 0);
        check("sys_rst_n", int'(sys_rst_n), (m_phase == PH_RUN) ? 1 : 0);
        check("locked", int'(locked), (m_phase == PH_RUN) ? 1 : 0);
        check("retry_cnt", int'(retry_cnt), m_retry);
        check("loss_cnt", int'(loss_cnt), m_loss);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    // Called at a falling edge; reset lands mid-cycle and is released on a falling edge.
    task automatic apply_reset();
        #2 reset = 1'b1;
        #1;
        model_reset();
        check_outputs();
        @(negedge clk);
        check_outputs();
        reset = 1'b0;
    endtask

    task automatic wait_sys(input logic level, input int bound, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (sys_rst_n !== level && n < bound);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        reset    = 1'b1;
        pll_lock = 1'b0;
        model_reset();
        @(negedge clk);
        check_outputs();
        reset = 1'b0;

        n = 0;
        do begin
            step();
            n++;
        end while (pll_reset === 1'b1 && n < 50);
        check("rst_pulse_len", n, R);
        repeat (10) step();
        pll_lock = 1'b1;
        wait_sys(1'b1, 100, n);
        check("release_lat", n, 3 + S);
        check("nominal_retry", int'(retry_cnt), 0);
        check("nominal_locked", int'(locked), 1);

        pll_lock = 1'b0;
        wait_sys(1'b0, 20, n);
        check("loss_lat", n, 3);
        check("loss_prst", int'(pll_reset), 1);
        check("loss_count", int'(loss_cnt), 1);
        repeat (2) step();
        pll_lock = 1'b1;
        wait_sys(1'b1, 200, n);
        check("relock", int'(sys_rst_n), 1);

        apply_reset();
        check("async_prst", int'(pll_reset), 1);
        check("async_loss", int'(loss_cnt), 0);

        pll_lock = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            repeat (R + T) step();
            check("retry_step", int'(retry_cnt), k);
            check("retry_prst", int'(pll_reset), 1);
        end

        apply_reset();
        repeat (R) step();
        pll_lock = 1'b1;
        repeat (3) step();
        pll_lock = 1'b0;
        step();
        pll_lock = 1'b1;
        wait_sys(1'b1, 60, n);
        check("glitch_lat", n, 3 + S);
        check("glitch_retry", int'(retry_cnt), 0);

        apply_reset();
        for (int seg = 0; seg < 300; seg++) begin
            int len;
            pll_lock = 1'($urandom_range(0, 1));
            len = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(1, 60);
            repeat (len) step();
            if ($urandom_range(0, 49) == 0) apply_reset();
        end

        apply_reset();
        pll_lock = 1'b0;
        repeat (260 * (R + T)) step();
        check("retry_sat", int'(retry_cnt), 255);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
